instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0, first word address written after reset.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted on the edge where in_valid and in_ready are both high.
REQ-007 SHALL have port op  input  4  operation in the pipeline's 4-bit ALUOp control code.
REQ-008 SHALL have ports rs, rt, rd  input  5 each  register fields.
REQ-009 SHALL have port imm  input  16  I-type immediate.
REQ-010 SHALL have port target  input  26  J-type target.
REQ-011 SHALL have port mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-012 SHALL have port mem_addr  output  ADDR_W  write word address.
REQ-013 SHALL have port mem_wdata  output  32  encoded instruction word.
REQ-014 SHALL have port count  output  ADDR_W+1  words written since reset.
REQ-015 SHALL have port full  output  1  no memory space remains.
REQ-016 SHALL have port err  output  1  sticky illegal-op flag.

Function
REQ-017 SHALL encode op 0000 as 0x00000000 (Noop).
REQ-018 SHALL encode ops 0001-1000 as R-type {6'b000000, rs, rt, rd, 5'b0, funct}, with funct 100000 add, 100010 sub, 100100 and, 100101 or, 011000 mult, 100110 xor, 100111 nor, 101010 slt.
REQ-019 SHALL encode op 1001 as {000100, rs, rt, imm} (beq), 1011 as {100011, rs, rt, imm} (lw), and 1100 as {101011, rs, rt, imm} (sw).
REQ-020 SHALL encode op 1010 as {000010, target} (j).
REQ-021 SHALL register each accepted legal request and drive mem_we high for exactly the next cycle, with mem_addr = BASE_ADDR + count (pre-increment) and mem_wdata = encoding (latency 1).
REQ-022 SHALL increment count by one per mem_we pulse.
REQ-023 SHALL accept ops 1101-1111, write nothing, leave count unchanged, and set err high until reset.
REQ-024 SHALL assert full when BASE_ADDR + count = 2^ADDR_W.
REQ-025 SHALL drive in_ready = !full and state = IDLE; requests presented while in_ready is low SHALL be ignored, not queued.
REQ-026 SHALL use states IDLE (accepting, back-to-back one word/cycle) and PAD (REQ-034); there SHALL be no address wrap-around.
REQ-027 SHALL keep mem_addr and mem_wdata at their last written values when mem_we is low.

Reset
REQ-028 SHALL, on reset high at a clock edge, set state=IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err=0, and in_ready=1 from the following cycle.
REQ-029 SHALL give reset priority over a simultaneous handshake; that request is dropped.
REQ-030 SHALL abort any in-progress padding on reset and suppress remaining pad writes.

Configuration
REQ-031 SHALL honour macro INSTR_ENCODER_PAD_NOP_EN.
REQ-032 SHALL, without the macro, never enter PAD.
REQ-033 SHALL, with the macro, enter PAD after writing a beq or j.
REQ-034 SHALL, in PAD, write three consecutive 0x00000000 words on the three cycles after the branch/jump write, with in_ready low throughout, then return to IDLE.
REQ-035 SHALL end PAD early, without further writes, if full asserts during padding.

Verification
REQ-036 Bench SHALL cover: reset, then add rs=1 rt=2 rd=3 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x00221820, count=1.
REQ-037 Bench SHALL cover: back-to-back lw rs=1 rt=2 imm=4, then j target=0x10 -> writes 0x8C220004 @0 then 0x08000010 @1 on consecutive cycles.
REQ-038 Bench SHALL cover: op 1110 -> no mem_we, count unchanged, err=1; a following legal request still writes.
REQ-039 Bench SHALL cover: ADDR_W=2, four legal writes -> full=1, in_ready=0; a fifth request produces no write.
REQ-040 Bench SHALL cover, macro defined: beq rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF @0, then 0x0 @1, @2, @3, in_ready low for 3 cycles; reset asserted during the second pad write -> no further writes, count=0.
REQ-041 Bench SHALL cover, macro undefined: same beq -> single write, in_ready high the next cycle.

Source files
------------

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
// Turns ALUOp-coded requests into 32-bit MIPS-style instruction words and
// writes them one per cycle into consecutive instruction-memory addresses.
//
// Optional build macro: INSTR_ENCODER_PAD_NOP_EN
//   When defined, every beq/j write is followed by three zero (nop) words.
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   synchronous active-high reset
//   in_valid   in   request present
//   in_ready   out  request accepted when in_valid && in_ready at an edge
//   op         in   4-bit ALUOp code
//   rs/rt/rd   in   5-bit register fields
//   imm        in   16-bit I-type immediate
//   target     in   26-bit J-type target
//   mem_we     out  one-cycle write strobe
//   mem_addr   out  write word address (ADDR_W)
//   mem_wdata  out  encoded instruction word
//   count      out  words written since reset (ADDR_W+1)
//   full       out  no memory space remains
//   err        out  sticky illegal-op flag
// ----------------------------------------------------------------------------
module instr_encoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam int unsigned CW = ADDR_W + 1;

`ifdef INSTR_ENCODER_PAD_NOP_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic {S_IDLE = 1'b0, S_PAD = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_pad_cnt;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [CW-1:0]     r_count;
    logic              r_err;

    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [31:0]       w_wdata_nxt;
    logic [CW-1:0]     w_count_nxt;
    logic              w_err_nxt;
    logic [1:0]        w_pad_nxt;

    logic              w_full;
    logic              w_accept;
    logic              w_legal;
    logic              w_is_br;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [31:0]       w_enc;

    // Sum never exceeds 2^ADDR_W because writes stop once it is reached
    assign w_full    = (CW'(BASE_ADDR) + r_count) == (CW'(1) << ADDR_W);
    assign in_ready  = (r_state == S_IDLE) && !w_full;
    assign w_accept  = in_valid && in_ready;
    assign w_legal   = (op <= 4'd12);
    assign w_is_br   = (op == 4'd9) || (op == 4'd10);
    assign w_wr_addr = ADDR_W'(BASE_ADDR) + r_count[ADDR_W-1:0];

    // Instruction word encoder
    always_comb begin
        w_enc = 32'h0000_0000;
        case (op)
            4'd1:  w_enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100000};
            4'd2:  w_enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100010};
            4'd3:  w_enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100100};
            4'd4:  w_enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100101};
            4'd5:  w_enc = {6'b000000, rs, rt, rd, 5'b0, 6'b011000};
            4'd6:  w_enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100110};
            4'd7:  w_enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100111};
            4'd8:  w_enc = {6'b000000, rs, rt, rd, 5'b0, 6'b101010};
            4'd9:  w_enc = {6'b000100, rs, rt, imm};
            4'd10: w_enc = {6'b000010, target};
            4'd11: w_enc = {6'b100011, rs, rt, imm};
            4'd12: w_enc = {6'b101011, rs, rt, imm};
            default: w_enc = 32'h0000_0000;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (PAD_EN && w_accept && w_is_br) begin
                    w_state_nxt = S_PAD;
                end
            end
            S_PAD: begin
                // Leave after the last pad word, or immediately once full
                if (w_full || (r_pad_cnt == 2'd1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_mem_addr;
        w_wdata_nxt = r_mem_wdata;
        w_count_nxt = r_count;
        w_err_nxt   = r_err;
        w_pad_nxt   = r_pad_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_legal) begin
                        w_we_nxt    = 1'b1;
                        w_addr_nxt  = w_wr_addr;
                        w_wdata_nxt = w_enc;
                        w_count_nxt = r_count + CW'(1);
                        if (PAD_EN && w_is_br) begin
                            w_pad_nxt = 2'd3;
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_PAD: begin
                if (!w_full) begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = w_wr_addr;
                    w_wdata_nxt = 32'h0000_0000;
                    w_count_nxt = r_count + CW'(1);
                    w_pad_nxt   = r_pad_cnt - 2'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= ADDR_W'(BASE_ADDR);
            r_mem_wdata <= 32'h0000_0000;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_pad_cnt   <= 2'd0;
        end else begin
            r_mem_we    <= w_we_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mem_wdata <= w_wdata_nxt;
            r_count     <= w_count_nxt;
            r_err       <= w_err_nxt;
            r_pad_cnt   <= w_pad_nxt;
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign count     = r_count;
    assign full      = w_full;
    assign err       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;

    // Default-width instance
    logic        m_in_ready, m_mem_we, m_full, m_err;
    logic [7:0]  m_mem_addr;
    logic [31:0] m_mem_wdata;
    logic [8:0]  m_count;

    // Four-word instance for capacity corners
    logic        s_in_ready, s_mem_we, s_full, s_err;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [2:0]  s_count;

    int n_checks = 0;
    int n_fail   = 0;

    instr_encoder u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .mem_we(m_mem_we), .mem_addr(m_mem_addr), .mem_wdata(m_mem_wdata),
        .count(m_count), .full(m_full), .err(m_err)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .count(s_count), .full(s_full), .err(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] target;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        reset    = 1'b0;
    endtask

    task automatic req(input logic [3:0] o, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] c, input logic [15:0] i, input logic [25:0] t);
        op = o; rs = a; rt = b; rd = c; imm = i; target = t;
        in_valid = 1'b1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0;
        op = '0; rs = '0; rt = '0; rd = '0; imm = '0; target = '0;

        //            op     rs     rt     rd     imm        target         we    wdata
        vecs[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,         1'b1, 32'h0000_0000};
        vecs[1]  = '{4'd1,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,         1'b1, 32'h0022_1820};
        vecs[2]  = '{4'd2,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,         1'b1, 32'h0022_1822};
        vecs[3]  = '{4'd3,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,         1'b1, 32'h0022_1824};
        vecs[4]  = '{4'd4,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,         1'b1, 32'h0022_1825};
        vecs[5]  = '{4'd5,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,         1'b1, 32'h0022_1818};
        vecs[6]  = '{4'd6,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,         1'b1, 32'h0022_1826};
        vecs[7]  = '{4'd7,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,         1'b1, 32'h0022_1827};
        vecs[8]  = '{4'd8,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,         1'b1, 32'h0022_182A};
        vecs[9]  = '{4'd1,  5'd31, 5'd0,  5'd31, 16'h0000, 26'h0,         1'b1, 32'h03E0_F820};
        vecs[10] = '{4'd9,  5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0,         1'b1, 32'h1022_FFFF};
        vecs[11] = '{4'd11, 5'd1,  5'd2,  5'd0,  16'h0004, 26'h0,         1'b1, 32'h8C22_0004};
        vecs[12] = '{4'd12, 5'd1,  5'd2,  5'd0,  16'h0004, 26'h0,         1'b1, 32'hAC22_0004};
        vecs[13] = '{4'd10, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF,   1'b1, 32'h0BFF_FFFF};
        vecs[14] = '{4'd13, 5'd1,  5'd2,  5'd3,  16'h1234, 26'h0,         1'b0, 32'h0000_0000};
        vecs[15] = '{4'd15, 5'd1,  5'd2,  5'd3,  16'h1234, 26'h0,         1'b0, 32'h0000_0000};

        // Reset state
        do_reset();
        chk("rst_we",    64'(m_mem_we),    64'd0);
        chk("rst_addr",  64'(m_mem_addr),  64'd0);
        chk("rst_wdata", 64'(m_mem_wdata), 64'd0);
        chk("rst_count", 64'(m_count),     64'd0);
        chk("rst_full",  64'(m_full),      64'd0);
        chk("rst_err",   64'(m_err),       64'd0);
        chk("rst_rdy",   64'(m_in_ready),  64'd1);

        // Encoding table: one request per fresh reset
        for (int i = 0; i < NV; i++) begin
            do_reset();
            req(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].target);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_we", i),    64'(m_mem_we),    64'(vecs[i].exp_we));
            chk($sformatf("v%0d_wdata", i), 64'(m_mem_wdata), 64'(vecs[i].exp_wdata));
            chk($sformatf("v%0d_addr", i),  64'(m_mem_addr),  64'd0);
            chk($sformatf("v%0d_count", i), 64'(m_count),     64'(vecs[i].exp_we));
            chk($sformatf("v%0d_err", i),   64'(m_err),       64'(!vecs[i].exp_we));
        end

        // Back-to-back lw then j
        do_reset();
        req(4'd11, 5'd1, 5'd2, 5'd0, 16'h0004, 26'h0);
        tick();
        chk("b2b_we0",    64'(m_mem_we),    64'd1);
        chk("b2b_addr0",  64'(m_mem_addr),  64'd0);
        chk("b2b_wdata0", 64'(m_mem_wdata), 64'h8C22_0004);
        req(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
        tick();
        in_valid = 1'b0;
        chk("b2b_we1",    64'(m_mem_we),    64'd1);
        chk("b2b_addr1",  64'(m_mem_addr),  64'd1);
        chk("b2b_wdata1", 64'(m_mem_wdata), 64'h0800_0010);
        chk("b2b_count",  64'(m_count),     64'd2);

        // Illegal op then legal request; outputs hold afterwards
        do_reset();
        req(4'd14, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        chk("ill_we",    64'(m_mem_we),   64'd0);
        chk("ill_count", 64'(m_count),    64'd0);
        chk("ill_err",   64'(m_err),      64'd1);
        chk("ill_rdy",   64'(m_in_ready), 64'd1);
        req(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        in_valid = 1'b0;
        chk("ill2_we",    64'(m_mem_we),    64'd1);
        chk("ill2_wdata", 64'(m_mem_wdata), 64'h0022_1820);
        chk("ill2_count", 64'(m_count),     64'd1);
        chk("ill2_err",   64'(m_err),       64'd1);
        tick();
        chk("hold_we",    64'(m_mem_we),    64'd0);
        chk("hold_addr",  64'(m_mem_addr),  64'd0);
        chk("hold_wdata", 64'(m_mem_wdata), 64'h0022_1820);
        chk("hold_err",   64'(m_err),       64'd1);

        // Fill the four-word instance, then a fifth request is ignored
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req(4'd1, 5'(i), 5'd2, 5'd3, 16'h0, 26'h0);
            tick();
            chk($sformatf("fill%0d_we", i),   64'(s_mem_we),   64'd1);
            chk($sformatf("fill%0d_addr", i), 64'(s_mem_addr), 64'(i));
        end
        in_valid = 1'b0;
        chk("full_flag",  64'(s_full),     64'd1);
        chk("full_rdy",   64'(s_in_ready), 64'd0);
        chk("full_count", 64'(s_count),    64'd4);
        req(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        in_valid = 1'b0;
        chk("full5_we",    64'(s_mem_we),    64'd0);
        chk("full5_count", 64'(s_count),     64'd4);
        chk("full5_addr",  64'(s_mem_addr),  64'd3);

`ifdef INSTR_ENCODER_PAD_NOP_EN
        // beq followed by three nop pad words
        do_reset();
        req(4'd9, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
        tick();
        in_valid = 1'b0;
        chk("pad_br_we",    64'(m_mem_we),    64'd1);
        chk("pad_br_addr",  64'(m_mem_addr),  64'd0);
        chk("pad_br_wdata", 64'(m_mem_wdata), 64'h1022_FFFF);
        chk("pad_br_rdy",   64'(m_in_ready),  64'd0);
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1;    // offered while padding; must be ignored
            op = 4'd1;
            tick();
            chk($sformatf("pad%0d_we", k),    64'(m_mem_we),    64'd1);
            chk($sformatf("pad%0d_addr", k),  64'(m_mem_addr),  64'(k));
            chk($sformatf("pad%0d_wdata", k), 64'(m_mem_wdata), 64'd0);
            chk($sformatf("pad%0d_rdy", k),   64'(m_in_ready),  64'(k == 3));
        end
        in_valid = 1'b0;
        chk("pad_count", 64'(m_count), 64'd4);
        tick();
        chk("pad_end_we", 64'(m_mem_we), 64'd0);

        // Reset aborts padding: reset edge replaces the second pad write
        do_reset();
        req(4'd9, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("abort_pad1_we", 64'(m_mem_we), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_we0",    64'(m_mem_we),   64'd0);
        chk("abort_count0", 64'(m_count),    64'd0);
        tick();
        chk("abort_we1",    64'(m_mem_we),   64'd0);
        chk("abort_count1", 64'(m_count),    64'd0);
        chk("abort_rdy",    64'(m_in_ready), 64'd1);
        tick();
        chk("abort_we2",    64'(m_mem_we),   64'd0);

        // Padding cut short by full on the four-word instance
        do_reset();
        req(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        tick();
        req(4'd9, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
        tick();
        in_valid = 1'b0;
        chk("pfull_br_addr",  64'(s_mem_addr),  64'd2);
        chk("pfull_br_wdata", 64'(s_mem_wdata), 64'h1022_FFFF);
        tick();
        chk("pfull_pad_we",   64'(s_mem_we),    64'd1);
        chk("pfull_pad_addr", 64'(s_mem_addr),  64'd3);
        chk("pfull_full",     64'(s_full),      64'd1);
        tick();
        chk("pfull_stop_we",  64'(s_mem_we),    64'd0);
        chk("pfull_count",    64'(s_count),     64'd4);
        tick();
        chk("pfull_stop_we2", 64'(s_mem_we),    64'd0);
`else
        // Without padding a beq is a single write
        do_reset();
        req(4'd9, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
        tick();
        in_valid = 1'b0;
        chk("nopad_we",    64'(m_mem_we),    64'd1);
        chk("nopad_wdata", 64'(m_mem_wdata), 64'h1022_FFFF);
        chk("nopad_rdy",   64'(m_in_ready),  64'd1);
        tick();
        chk("nopad_we2",   64'(m_mem_we),    64'd0);
        chk("nopad_count", 64'(m_count),     64'd1);
`endif

        // Reset wins over a simultaneous handshake
        do_reset();
        req(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        chk("rstpri_we",    64'(m_mem_we), 64'd0);
        chk("rstpri_count", 64'(m_count),  64'd0);
        tick();
        chk("rstpri_we2",   64'(m_mem_we), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
